// File: rtl/fft_stage_ctrl.sv
// Stage sequencer for a single shared radix-2 DIF butterfly running an in-place N-point FFT.
// Optional FFT_CTRL_OVF_ABORT_EN: the first qualified butterfly overflow aborts the transform.
module fft_stage_ctrl #(
  parameter int N_LOG2 = 8,
  parameter int BF_LAT = 3,
  parameter int RD_LAT = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              rd_en,
  output logic [N_LOG2-1:0]                 rd_addr_a,
  output logic [N_LOG2-1:0]                 rd_addr_b,
  output logic [N_LOG2-2:0]                 tw_addr,
  output logic                              bf_en,
  input  logic                              bf_vld_out,
  input  logic                              bf_overflow,
  output logic                              wr_en,
  output logic [N_LOG2-1:0]                 wr_addr_a,
  output logic [N_LOG2-1:0]                 wr_addr_b,
  output logic [$clog2(N_LOG2+1)-1:0]       stage,
  output logic                              ovf,
  output logic                              seq_err
);

  localparam int A    = N_LOG2;
  localparam int TW   = N_LOG2 - 1;
  localparam int SW   = $clog2(N_LOG2 + 1);
  localparam int L    = RD_LAT + BF_LAT;
  localparam int HALF = 1 << (N_LOG2 - 1);
  // Every pipeline slot except the oldest; zero means the current write-back is the last one.
  localparam logic [L-1:0] PEND_MASK = L'((1 << (L - 1)) - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t         state;
  logic [A-1:0]   j;
  logic [L-1:0]   vpipe;
  logic [A-1:0]   apipe [L];
  logic [A-1:0]   bpipe [L];
  logic           abort;

  int unsigned    c_stage, c_j, c_span, c_a;
  logic [A-1:0]   nxt_a, nxt_b, nxt_span;
  logic [TW-1:0]  nxt_tw;

`ifdef FFT_CTRL_OVF_ABORT_EN
  assign abort = bf_vld_out & bf_overflow;
`else
  assign abort = 1'b0;
`endif

  // Butterfly j of the current stage; nxt_span is the b-offset of butterfly 0 in the next stage.
  always_comb begin
    c_stage  = 32'(stage);
    c_j      = 32'(j);
    c_span   = 32'(1) << (N_LOG2 - 1 - c_stage);
    c_a      = ((c_j >> (N_LOG2 - 1 - c_stage)) << (N_LOG2 - c_stage)) | (c_j & (c_span - 1));
    nxt_a    = A'(c_a);
    nxt_b    = A'(c_a | c_span);
    nxt_tw   = TW'((c_j & (c_span - 1)) << c_stage);
    nxt_span = A'(c_span >> 1);
  end

  assign bf_en     = vpipe[RD_LAT-1];
  assign wr_en     = vpipe[L-1];
  assign wr_addr_a = wr_en ? apipe[L-1] : '0;
  assign wr_addr_b = wr_en ? bpipe[L-1] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
      j         <= '0;
      stage     <= '0;
      ovf       <= 1'b0;
      seq_err   <= 1'b0;
      vpipe     <= '0;
      for (int unsigned k = 0; k < L; k++) begin
        apipe[k] <= '0;
        bpipe[k] <= '0;
      end
    end else begin
      vpipe[0] <= rd_en;
      apipe[0] <= rd_addr_a;
      bpipe[0] <= rd_addr_b;
      for (int unsigned k = 1; k < L; k++) begin
        vpipe[k] <= vpipe[k-1];
        apipe[k] <= apipe[k-1];
        bpipe[k] <= bpipe[k-1];
      end

      if (bf_vld_out != vpipe[L-1]) seq_err <= 1'b1;
      if (busy && bf_vld_out && bf_overflow) ovf <= 1'b1;

      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;

      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            stage     <= '0;
            j         <= A'(1);
            rd_en     <= 1'b1;
            rd_addr_b <= A'(HALF);
            ovf       <= 1'b0;
            seq_err   <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= FIN;
            busy  <= 1'b0;
            vpipe <= '0;
          end else if (j == A'(HALF)) begin
            state <= DRAIN;
          end else begin
            rd_en     <= 1'b1;
            rd_addr_a <= nxt_a;
            rd_addr_b <= nxt_b;
            tw_addr   <= nxt_tw;
            j         <= j + A'(1);
          end
        end
        DRAIN: begin
          if (abort) begin
            state <= FIN;
            busy  <= 1'b0;
            vpipe <= '0;
          end else if ((vpipe & PEND_MASK) == '0) begin
            if (stage == SW'(N_LOG2 - 1)) begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= RUN;
              stage     <= stage + SW'(1);
              j         <= A'(1);
              rd_en     <= 1'b1;
              rd_addr_b <= nxt_span;
            end
          end
        end
        FIN: begin
          // Normal completion arrives with done already set; an abort arrives with it clear.
          if (done) begin
            done  <= 1'b0;
            state <= IDLE;
            stage <= '0;
          end else begin
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fft_stage_ctrl.md
Name: fft_stage_ctrl

Overview:
- Sequences one shared fixed-point radix-2 butterfly through all stages of an in-place N-point FFT (N = 2^N_LOG2, default 256).
- Issues ping-side RAM reads, twiddle ROM addresses, butterfly enables and aligned write-backs.
- Drains the butterfly pipeline between stages to avoid read-after-write hazards.
- Accumulates the butterfly overflow flag as a per-transform status.

Parameters:
- N_LOG2, 8, log2 of FFT size; stages = N_LOG2, butterflies per stage = 2^(N_LOG2-1).
- BF_LAT, 3, butterfly latency in cycles from en to vld_out.
- RD_LAT, 1, data RAM read latency in cycles from rd_en to data valid at butterfly inputs.

Ports:
- clk, in, 1, single clock, rising edge.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, one-cycle request to begin a transform; ignored unless in IDLE.
- busy, out, 1, high from the first issue cycle through the last write-back.
- done, out, 1, one-cycle pulse after the final write-back.
- rd_en, out, 1, read strobe for the RAM A/B ports.
- rd_addr_a, out, N_LOG2, upper butterfly operand address.
- rd_addr_b, out, N_LOG2, lower butterfly operand address.
- tw_addr, out, N_LOG2-1, twiddle ROM index (sin/cos pair).
- bf_en, out, 1, butterfly input-valid (en); equals rd_en delayed RD_LAT.
- bf_vld_out, in, 1, butterfly output valid.
- bf_overflow, in, 1, butterfly overflow flag, qualified by bf_vld_out.
- wr_en, out, 1, write strobe; equals bf_en delayed BF_LAT.
- wr_addr_a, out, N_LOG2, write address for y1.
- wr_addr_b, out, N_LOG2, write address for y2.
- stage, out, ceil(log2(N_LOG2+1)), current stage index; 0 in IDLE.
- ovf, out, 1, sticky overflow for the current or last transform.
- seq_err, out, 1, sticky; set when bf_vld_out != internal wr_en in any cycle.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; delay lines flushed. Mid-transform reset aborts with no done pulse; it takes effect on the next edge.
- FSM states: IDLE, RUN, DRAIN, FIN.
  - IDLE: on start, clear ovf and seq_err, set stage=0, j=0, go to RUN. start in any other state is ignored.
  - RUN: assert rd_en with addresses for butterfly j, then j++. After j = 2^(N_LOG2-1)-1, go to DRAIN.
  - DRAIN: wait until the in-flight count is 0, i.e. the last wr_en has fired. If stage = N_LOG2-1, go to FIN; otherwise stage++, j=0, go to RUN.
  - FIN: done=1 for one cycle, busy=0, go to IDLE.
- Address generation (DIF, natural-order input):
  - span = 2^(N_LOG2-1-stage)
  - rd_addr_a = (j >> (N_LOG2-1-stage)) * 2*span + (j mod span)
  - rd_addr_b = rd_addr_a + span
  - tw_addr = (j mod span) << stage
- Write path: the addresses propagate through a RD_LAT+BF_LAT shift register alongside the valid bit. wr_addr_a/b equal the rd addresses issued RD_LAT+BF_LAT cycles earlier, and output 0 when wr_en=0.
- Stage period = 2^(N_LOG2-1) + RD_LAT + BF_LAT cycles. The first rd_en of stage s+1 occurs the cycle after the last wr_en of stage s.
- ovf |= bf_overflow & bf_vld_out every cycle while busy.
- Simultaneous start and rst: rst wins.
- start in the same cycle as done (FIN): ignored; a new start must be presented while in IDLE.

Optional Feature:
- FFT_CTRL_OVF_ABORT_EN defined: the first qualified bf_overflow sets ovf and forces FIN on the next cycle. rd_en stops immediately, in-flight write-backs are suppressed (wr_en forced 0), and done pulses.
- Undefined: overflow is only recorded in ovf and the transform always runs to completion.

Test Plan:
- N_LOG2=3, BF_LAT=3, RD_LAT=1; start pulse in cycle 0, bf_vld_out tied to wr_en:
  - rd_en in cycles 1-4, 9-12 and 17-20; wr_en in cycles 5-8, 13-16 and 21-24.
  - busy high in cycles 1-24; done pulses in cycle 25.
- Same config, address check:
  - Stage 0: pairs (0,4),(1,5),(2,6),(3,7), tw 0,1,2,3.
  - Stage 1: pairs (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2.
  - Stage 2: pairs (0,1),(2,3),(4,5),(6,7), tw 0.
  - wr addresses repeat the same sequence 4 cycles later.
- Defaults (N_LOG2=8): 8 stages x (128+4) cycles; done pulses at cycle 1057. Final-stage pairs are (2k, 2k+1).
- Overflow: inject bf_overflow=1 with bf_vld_out in cycle 6 (N_LOG2=3).
  - Without the macro: ovf=1 from cycle 7 and done at cycle 25.
  - With FFT_CTRL_OVF_ABORT_EN: done at cycle 8 and no wr_en after cycle 6.
- Pulse rst in cycle 10 during stage 1: the next cycle shows busy=0, all strobes 0, stage=0 and no done pulse. A start in cycle 12 reruns the full sequence relative to cycle 12.
- Extra start pulses in cycle 3 and in the FIN cycle are ignored (schedule unchanged). Delaying bf_vld_out by 1 cycle sets seq_err.
